// File: rtl/gpio_apb_arbiter_if.sv
// Client req/done ports and APB master port of gpio_apb_arbiter, bundled as one interface.
// modport master = arbiter side; modport slave = the two clients plus the GPIO APB slave.
interface gpio_apb_arbiter_if #(
  parameter int GPIO_PINS  = 32,
  parameter int PADDR_SIZE = 4
);
  logic                     m0_req,   m1_req;
  logic [PADDR_SIZE-1:0]    m0_addr,  m1_addr;
  logic                     m0_write, m1_write;
  logic [GPIO_PINS-1:0]     m0_wdata, m1_wdata;
  logic [GPIO_PINS/8-1:0]   m0_strb,  m1_strb;
  logic                     m0_done,  m1_done;
  logic [GPIO_PINS-1:0]     m0_rdata, m1_rdata;
  logic                     m0_err,   m1_err;

  logic                     PSEL;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [PADDR_SIZE-1:0]    PADDR;
  logic [GPIO_PINS-1:0]     PWDATA;
  logic [GPIO_PINS/8-1:0]   PSTRB;
  logic                     PREADY;
  logic                     PSLVERR;
  logic [GPIO_PINS-1:0]     PRDATA;

  modport master (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_write, m1_write,
           m0_wdata, m1_wdata, m0_strb, m1_strb,
    output m0_done, m1_done, m0_rdata, m1_rdata, m0_err, m1_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    output m0_req, m1_req, m0_addr, m1_addr, m0_write, m1_write,
           m0_wdata, m1_wdata, m0_strb, m1_strb,
    input  m0_done, m1_done, m0_rdata, m1_rdata, m0_err, m1_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/gpio_apb_arbiter.sv
// Round-robin two-client APB master in front of the GPIO register slave.
// Define GPIO_ARB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES with err=1.
module gpio_apb_arbiter #(
  parameter int GPIO_PINS      = 32,
  parameter int PADDR_SIZE     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               HRESETn,
  gpio_apb_arbiter_if.master bus,
  output logic               busy
);

  localparam int STRB_W = GPIO_PINS / 8;

  if (((GPIO_PINS % 8) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_cfg_check
    $error("gpio_apb_arbiter: GPIO_PINS must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_last_grant;
  logic                    r_owner;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [PADDR_SIZE-1:0]   r_paddr;
  logic [GPIO_PINS-1:0]    r_pwdata;
  logic [STRB_W-1:0]       r_pstrb;

  logic [1:0]              w_req;
  logic [PADDR_SIZE-1:0]   w_addr  [2];
  logic [1:0]              w_write;
  logic [GPIO_PINS-1:0]    w_wdata [2];
  logic [STRB_W-1:0]       w_strb  [2];
  logic                    w_winner;
  logic                    w_grant;
  logic                    w_complete;
  logic                    w_timeout;
  logic                    w_end;

  assign w_req      = {bus.m1_req, bus.m0_req};
  assign w_write    = {bus.m1_write, bus.m0_write};
  assign w_addr[0]  = bus.m0_addr;
  assign w_addr[1]  = bus.m1_addr;
  assign w_wdata[0] = bus.m0_wdata;
  assign w_wdata[1] = bus.m1_wdata;
  assign w_strb[0]  = bus.m0_strb;
  assign w_strb[1]  = bus.m1_strb;

  // On a tie the client that did not win last time goes next.
  always_comb begin
    w_winner = 1'b0;
    if (w_req[0] && w_req[1]) begin
      w_winner = ~r_last_grant;
    end else if (w_req[1]) begin
      w_winner = 1'b1;
    end
  end

  assign w_grant    = (r_state == ST_IDLE) && (w_req != 2'b00);
  assign w_complete = (r_state == ST_ACCESS) && bus.PREADY;
  assign w_end      = w_complete || w_timeout;

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_access_cnt;

  always_ff @(posedge CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_access_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_access_cnt <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_access_cnt <= r_access_cnt + 1'b1;
    end
  end

  // Counter holds the number of ACCESS cycles already spent before this one.
  assign w_timeout = (r_state == ST_ACCESS) && !bus.PREADY &&
                     (r_access_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: if (w_end) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_psel    <= (w_state_next != ST_IDLE);
      r_penable <= (w_state_next == ST_ACCESS);
      if (w_grant) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
        r_pwrite     <= w_write[w_winner];
        r_paddr      <= w_addr[w_winner];
        r_pwdata     <= w_write[w_winner] ? w_wdata[w_winner] : '0;
        r_pstrb      <= w_write[w_winner] ? w_strb[w_winner]  : '0;
      end
    end
  end

  logic [1:0]           w_done;
  logic [1:0]           w_err;
  logic [GPIO_PINS-1:0] w_rdata [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      logic                 r_done;
      logic                 r_err;
      logic [GPIO_PINS-1:0] r_rdata;
      logic                 w_hit;

      assign w_hit = w_end && (r_owner == 1'(gi));

      // rdata only moves on a successful read; err moves on every done.
      always_ff @(posedge CLK or negedge HRESETn) begin
        if (!HRESETn) begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end else begin
          r_done <= w_hit;
          if (w_hit) begin
            r_err <= w_timeout ? 1'b1 : bus.PSLVERR;
            if (w_complete && !r_pwrite) begin
              r_rdata <= bus.PRDATA;
            end
          end
        end
      end

      assign w_done[gi]  = r_done;
      assign w_err[gi]   = r_err;
      assign w_rdata[gi] = r_rdata;
    end
  endgenerate

  assign bus.m0_done  = w_done[0];
  assign bus.m1_done  = w_done[1];
  assign bus.m0_err   = w_err[0];
  assign bus.m1_err   = w_err[1];
  assign bus.m0_rdata = w_rdata[0];
  assign bus.m1_rdata = w_rdata[1];

  assign bus.PSEL    = r_psel;
  assign bus.PENABLE = r_penable;
  assign bus.PWRITE  = r_pwrite;
  assign bus.PADDR   = r_paddr;
  assign bus.PWDATA  = r_pwdata;
  assign bus.PSTRB   = r_pstrb;

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Randomized bench for gpio_apb_arbiter: a transaction-level model predicts grant order,
// completion cycle, APB phases and per-client rdata/err; timeout cases follow GPIO_ARB_TIMEOUT_EN.
module tb_gpio_apb_arbiter;
  localparam int PINS = 32;
  localparam int AW   = 4;
  localparam int SW   = PINS / 8;
  localparam int TMO  = 16;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [PINS-1:0] wdata;
    logic [SW-1:0] strb;
  } cmd_t;

  logic CLK = 1'b0;
  logic HRESETn;
  logic busy;
  int   checks   = 0;
  int   failures = 0;

  bit              m_last_grant;
  logic [PINS-1:0] m_rdata [2];
  logic            m_err   [2];

  gpio_apb_arbiter_if #(.GPIO_PINS(PINS), .PADDR_SIZE(AW)) bus ();

  gpio_apb_arbiter #(
    .GPIO_PINS(PINS), .PADDR_SIZE(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .HRESETn(HRESETn), .bus(bus), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.write = 1'($urandom_range(0, 1));
    c.addr  = AW'($urandom);
    c.wdata = $urandom;
    c.strb  = SW'($urandom);
    return c;
  endfunction

  task automatic model_reset();
    m_last_grant = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_rdata[i] = '0;
      m_err[i]   = 1'b0;
    end
  endtask

  // One arbitrated access from the first IDLE edge to the done cycle, checked every cycle.
  task automatic xfer(input bit r0, input bit r1, input cmd_t c0, input cmd_t c1,
                      input int waits, input bit slverr, input logic [PINS-1:0] prdata,
                      input bit hold, output int got);
    bit              w;
    bit              to;
    int              e_done;
    cmd_t            c;
    logic [PINS-1:0] ewd;
    logic [SW-1:0]   es;
    cmd_t            junk;
    w = (r0 && r1) ? !m_last_grant : r1;
    m_last_grant = w;
    c   = w ? c1 : c0;
    ewd = c.write ? c.wdata : '0;
    es  = c.write ? c.strb  : '0;
    to = 1'b0;
    e_done = waits + 2;
`ifdef GPIO_ARB_TIMEOUT_EN
    if (waits >= TMO) begin
      to = 1'b1;
      e_done = TMO + 1;
    end
`endif
    got = -1;
    bus.m0_req = r0;       bus.m1_req = r1;
    bus.m0_write = c0.write; bus.m1_write = c1.write;
    bus.m0_addr = c0.addr;   bus.m1_addr = c1.addr;
    bus.m0_wdata = c0.wdata; bus.m1_wdata = c1.wdata;
    bus.m0_strb = c0.strb;   bus.m1_strb = c1.strb;
    bus.PSLVERR = slverr;
    bus.PRDATA  = prdata;
    for (int e = 0; e <= e_done; e++) begin
      bus.PREADY = (e >= waits + 2);
      tick();
      if (e == e_done) begin
        m_err[w] = to ? 1'b1 : slverr;
        if (!to && !c.write) m_rdata[w] = prdata;
        got = bus.m1_done ? 1 : (bus.m0_done ? 0 : -1);
        checks++;
        if ({bus.PSEL, bus.PENABLE, busy, bus.m0_done, bus.m1_done} !== {3'b000, !w, w}) begin
          failures++;
          $display("FAIL done_cycle e=%0d got psel/pen/busy/d0/d1=%b exp=%b",
                   e, {bus.PSEL, bus.PENABLE, busy, bus.m0_done, bus.m1_done}, {3'b000, !w, w});
        end
      end else begin
        checks++;
        if ({bus.PSEL, bus.PENABLE, busy, bus.m0_done, bus.m1_done} !== {1'b1, (e >= 1), 1'b1, 2'b00}) begin
          failures++;
          $display("FAIL apb_phase e=%0d got psel/pen/busy/d0/d1=%b exp=%b",
                   e, {bus.PSEL, bus.PENABLE, busy, bus.m0_done, bus.m1_done}, {1'b1, (e >= 1), 1'b1, 2'b00});
        end
        checks++;
        if ({bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB} !== {c.write, c.addr, ewd, es}) begin
          failures++;
          $display("FAIL apb_cmd e=%0d got w=%b a=%h d=%h s=%h exp w=%b a=%h d=%h s=%h",
                   e, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, c.write, c.addr, ewd, es);
        end
        if (e == 0 && !hold) begin
          junk = rand_cmd();
          bus.m0_req = 1'($urandom_range(0, 1));
          bus.m1_req = 1'($urandom_range(0, 1));
          bus.m0_write = junk.write; bus.m1_write = ~junk.write;
          bus.m0_addr = junk.addr;   bus.m1_addr = ~junk.addr;
          bus.m0_wdata = junk.wdata; bus.m1_wdata = ~junk.wdata;
          bus.m0_strb = junk.strb;   bus.m1_strb = ~junk.strb;
        end
      end
      checks++;
      if ({bus.m0_rdata, bus.m0_err, bus.m1_rdata, bus.m1_err} !== {m_rdata[0], m_err[0], m_rdata[1], m_err[1]}) begin
        failures++;
        $display("FAIL client_status e=%0d got r0=%h e0=%b r1=%h e1=%b exp r0=%h e0=%b r1=%h e1=%b",
                 e, bus.m0_rdata, bus.m0_err, bus.m1_rdata, bus.m1_err,
                 m_rdata[0], m_err[0], m_rdata[1], m_err[1]);
      end
    end
    if (!hold) begin
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
    end
    $display("xfer req=%b%b winner=m%0d %s addr=%h wdata=%h prdata=%h waits=%0d slverr=%b timeout=%b done_edge=%0d",
             r1, r0, w, c.write ? "WR" : "RD", c.addr, ewd, prdata, waits, slverr, to, e_done);
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    bus.m0_write = 1'b0; bus.m1_write = 1'b0;
    bus.m0_addr = '0; bus.m1_addr = '0;
    bus.m0_wdata = '0; bus.m1_wdata = '0;
    bus.m0_strb = '0; bus.m1_strb = '0;
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
    model_reset();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, busy,
           bus.m0_done, bus.m1_done, bus.m0_rdata, bus.m1_rdata, bus.m0_err, bus.m1_err} !== '0) begin
        failures++;
        $display("FAIL reset_values phase=%0d got psel=%b pen=%b pw=%b pa=%h pd=%h ps=%h busy=%b d=%b%b r0=%h r1=%h e=%b%b exp all zero",
                 k, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB, busy,
                 bus.m1_done, bus.m0_done, bus.m0_rdata, bus.m1_rdata, bus.m1_err, bus.m0_err);
      end
      HRESETn = 1'b1;
      tick();
    end
  endtask

  task automatic test_m0_write();
    cmd_t c;
    int   got;
    c = '{write: 1'b1, addr: 4'd1, wdata: 32'hA5A5_0F0F, strb: 4'hF};
    xfer(1'b1, 1'b0, c, rand_cmd(), 0, 1'b0, $urandom, 1'b0, got);
    checks++;
    if (got !== 0) begin
      failures++;
      $display("FAIL m0_write_owner got=%0d exp=0", got);
    end
    tick();
  endtask

  task automatic test_m1_read();
    cmd_t c;
    int   got;
    c = '{write: 1'b0, addr: 4'd3, wdata: 32'hDEAD_BEEF, strb: 4'hF};
    xfer(1'b0, 1'b1, rand_cmd(), c, 2, 1'b0, 32'h1234_5678, 1'b0, got);
    checks++;
    if ({bus.m1_rdata, bus.m1_err} !== {32'h1234_5678, 1'b0}) begin
      failures++;
      $display("FAIL m1_read_data got rdata=%h err=%b exp rdata=12345678 err=0", bus.m1_rdata, bus.m1_err);
    end
    tick();
  endtask

  task automatic test_slave_error();
    cmd_t c;
    int   got;
    c = rand_cmd();
    c.write = 1'b1;
    xfer(1'b1, 1'b0, c, rand_cmd(), 1, 1'b1, $urandom, 1'b0, got);
    checks++;
    if (bus.m0_err !== 1'b1) begin
      failures++;
      $display("FAIL slverr_set got m0_err=%b exp=1", bus.m0_err);
    end
    tick();
    xfer(1'b1, 1'b0, rand_cmd(), rand_cmd(), 0, 1'b0, $urandom, 1'b0, got);
    checks++;
    if (bus.m0_err !== 1'b0) begin
      failures++;
      $display("FAIL slverr_clear got m0_err=%b exp=0", bus.m0_err);
    end
    tick();
  endtask

  task automatic test_fairness(input bit exp_first);
    cmd_t c0;
    cmd_t c1;
    int   got;
    c0 = rand_cmd(); c0.addr = 4'h2;
    c1 = rand_cmd(); c1.addr = 4'h5;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, 1'b1, c0, c1, 0, 1'b0, $urandom, (i < 3), got);
      checks++;
      if (got !== int'(exp_first ^ 1'(i))) begin
        failures++;
        $display("FAIL fairness_grant idx=%0d got=m%0d exp=m%0d", i, got, exp_first ^ 1'(i));
      end
    end
    tick();
  endtask

  task automatic test_random();
    int   v;
    int   sel;
    int   waits;
    int   got;
    for (int i = 0; i < 24; i++) begin
      v   = $urandom_range(1, 3);
      sel = $urandom_range(0, 9);
      waits = $urandom_range(0, 3);
`ifdef GPIO_ARB_TIMEOUT_EN
      if (sel == 8) waits = TMO - 1;
      if (sel == 9) waits = TMO + $urandom_range(0, 5);
`else
      if (sel >= 8) waits = $urandom_range(4, 8);
`endif
      xfer(1'(v), 1'(v >> 1), rand_cmd(), rand_cmd(), waits, 1'($urandom_range(0, 1)),
           $urandom, (i < 23) && ($urandom_range(0, 2) == 0), got);
    end
    tick();
  endtask

  task automatic test_timeout();
    cmd_t c;
    int   got;
    c = rand_cmd();
    c.write = 1'b0;
    xfer(1'b1, 1'b0, c, rand_cmd(), 100, 1'b0, $urandom, 1'b0, got);
`ifdef GPIO_ARB_TIMEOUT_EN
    checks++;
    if (bus.m0_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err got m0_err=%b exp=1", bus.m0_err);
    end
    tick();
    xfer(1'b0, 1'b1, rand_cmd(), c, TMO - 1, 1'b0, $urandom, 1'b0, got);
    tick();
    xfer(1'b0, 1'b1, rand_cmd(), c, TMO, 1'b0, $urandom, 1'b0, got);
`endif
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    cmd_t c;
    c = rand_cmd();
    bus.m1_req = 1'b1;
    bus.m1_write = c.write; bus.m1_addr = c.addr; bus.m1_wdata = c.wdata; bus.m1_strb = c.strb;
    bus.PREADY = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
      failures++;
      $display("FAIL mid_reset_access got psel/pen=%b exp=11", {bus.PSEL, bus.PENABLE});
    end
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if ({bus.PSEL, bus.PENABLE, busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_async got psel/pen/busy=%b exp=000", {bus.PSEL, bus.PENABLE, busy});
    end
    bus.m1_req = 1'b0;
    bus.PREADY = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err, bus.m0_rdata, bus.m1_rdata, bus.PSEL} !== '0) begin
        failures++;
        $display("FAIL mid_reset_no_done k=%0d got d=%b%b e=%b%b r0=%h r1=%h psel=%b exp all zero",
                 k, bus.m1_done, bus.m0_done, bus.m1_err, bus.m0_err, bus.m0_rdata, bus.m1_rdata, bus.PSEL);
      end
    end
    HRESETn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_slave_error();
    test_fairness(!m_last_grant);
    test_random();
    test_timeout();
    test_reset_mid_transfer();
    test_fairness(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_apb_arbiter.md
# gpio_apb_arbiter

Two-requester APB master arbiter that shares the single GPIO APB slave port (MODE, DIRECTION, OUTPUT, INPUT, TR_*, IRQ_EN registers) between two on-chip clients, e.g. a CPU bridge and a hardware pin sequencer. Each client issues one register access at a time over a simple req/done handshake. The arbiter grants clients round-robin, runs the APB SETUP/ACCESS phases toward the GPIO, and returns read data and the slave error.

## Interface
- GPIO_PINS, 32, data width; must be a multiple of 8
- PADDR_SIZE, 4, APB address width
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only with the timeout feature
- CLK  in  1  single clock, rising edge
- HRESETn  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1  client access request; held until done
- m0_addr, m1_addr  in  PADDR_SIZE  register address
- m0_write, m1_write  in  1  1 = write, 0 = read
- m0_wdata, m1_wdata  in  GPIO_PINS  write data
- m0_strb, m1_strb  in  GPIO_PINS/8  write byte strobes
- m0_done, m1_done  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  GPIO_PINS  read data, valid with done
- m0_err, m1_err  out  1  error status, valid with done
- busy  out  1  FSM not in IDLE
- PSEL, PENABLE, PWRITE  out  1  APB master controls
- PADDR  out  PADDR_SIZE  APB address
- PWDATA  out  GPIO_PINS  APB write data
- PSTRB  out  GPIO_PINS/8  APB strobes
- PREADY, PSLVERR  in  1  APB slave response
- PRDATA  in  GPIO_PINS  APB read data

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - PSEL=0, PENABLE=0.
  - On a clock edge with any req high: pick a winner, latch its addr, write, wdata and strb into the APB output registers, go to SETUP.
- **Arbitration:** round-robin on the last_grant register (reset value 1, so m0 wins the first tie).
  - Single requester: that requester wins.
  - Both requesting: the requester not granted last time wins.
  - last_grant updates at grant.
- **SETUP:** PSEL=1, PENABLE=0; unconditionally go to ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS.
  - PREADY=1 at an edge: the transfer completes.
    - Winner's done goes high for one cycle.
    - Winner's err takes PSLVERR.
    - On reads, winner's rdata takes PRDATA.
    - FSM returns to IDLE.
- **Reads:** PWDATA=0, PSTRB=0.
- **Writes:** PWDATA and PSTRB are taken from the client.
- **Latched command:** sampled once at grant; client changes afterwards have no effect on the running transfer.
- **Deasserting req after grant** does not cancel the transfer; done still pulses.
- **req still high in the done cycle** counts as a new request at the next IDLE edge. Clients must drop req in the done cycle unless they want back-to-back accesses.
- **rdata / err hold:** rdata holds its last read value across writes; err holds until the next done for that client.
- The non-granted client sees no output change.

## Timing
- **Reset (async, HRESETn=0)**
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB = 0.
  - m*_done, m*_rdata, m*_err = 0.
  - busy=0, FSM=IDLE, last_grant=1.
  - Reset mid-transfer aborts immediately with no done pulse.
- **Zero-wait slave:** req sampled at edge 0 → SETUP after edge 0 → ACCESS after edge 1 → done high after edge 2 for one cycle.
  - Minimum spacing between APB transfers is 3 cycles, because IDLE is always visited once.
- **Wait states:** each PREADY=0 cycle in ACCESS adds one cycle of latency.
- **All outputs** are registered; no combinational path from req or PREADY to any output.
- **busy** is high in SETUP and ACCESS.

## Configuration
- **GPIO_ARB_TIMEOUT_EN defined**
  - An ACCESS-cycle counter clears on entry to SETUP.
  - If the counter reaches TIMEOUT_CYCLES with PREADY still low, the arbiter:
    - deasserts PSEL and PENABLE;
    - pulses the winner's done with err=1, leaving rdata unchanged;
    - returns to IDLE.
  - PREADY=1 on the final counted cycle completes the transfer normally.
- **GPIO_ARB_TIMEOUT_EN undefined**
  - The counter is absent and the arbiter waits in ACCESS indefinitely.
  - TIMEOUT_CYCLES is ignored.

## Test plan
- **Reset values:** hold HRESETn=0, then release → every output reads 0 and busy=0. Assert HRESETn=0 during ACCESS → PSEL and PENABLE drop asynchronously and no done pulse occurs.
- **m0 write:** m0 writes addr 1, data 32'hA5A5_0F0F, strb 4'hF, zero-wait slave → PSEL/PENABLE/PADDR/PWDATA match the APB sequence and m0_done pulses 3 cycles after req.
- **m1 read:** m1 reads addr 3 with PRDATA=32'h1234_5678 and 2 PREADY wait cycles → m1_rdata=32'h1234_5678, m1_err=0, done after 5 cycles, and PSTRB=0 throughout.
- **Fairness:** both clients hold req for 4 transfers → grants alternate m0, m1, m0, m1, with the 3-cycle gap between transfers.
- **Slave error:** PSLVERR=1 with PREADY on an m0 write → m0_err=1 in the done cycle; a following clean transfer clears m0_err to 0.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** PREADY held at 0 → done with err=1 after 16 ACCESS cycles, rdata unchanged, FSM back in IDLE. With the macro off, the bench checks that the arbiter is still in ACCESS after 100 cycles.
